// File: rtl/instr_mem_prog.sv
// Programmable instruction memory with a valid/ready load port and a registered fetch port.
// Only the region written by the most recent completed load can be fetched; anything else returns NOP_WORD.
module instr_mem_prog #(
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_start,
    input  logic                     prog_valid,
    input  logic [DATA_W-1:0]        prog_data,
    input  logic                     prog_last,
    output logic                     prog_ready,
    output logic                     prog_done,
    output logic [$clog2(DEPTH):0]   prog_len,
    output logic                     busy,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        A,
    output logic [DATA_W-1:0]        RD,
    output logic                     rd_valid,
    output logic                     fetch_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_cnt;
    logic [AW:0]         r_len;
    logic                r_done;
    logic [DATA_W-1:0]   r_rd;
    logic                r_rd_valid;
    logic                r_err;

    logic                w_load;
    logic                w_run;
    logic                w_accept;
    logic                w_final;
    logic                w_start;
    logic [AW-1:0]       w_idx;
    logic                w_bad;
    logic                w_serve;

    assign w_load   = (r_state == S_LOAD);
    assign w_run    = (r_state == S_RUN);
    assign w_accept = w_load && prog_valid;
    assign w_final  = w_accept && (prog_last || (r_cnt == AW'(DEPTH - 1)));
    assign w_start  = prog_start && !w_load;
    assign w_idx    = A[AW+1:2];
    assign w_serve  = fetch_req && !w_load;

    // Misaligned, beyond the loaded length, or outside the array.
    assign w_bad = (A[1:0] != 2'b00)
                 || ({1'b0, w_idx} >= r_len)
                 || (A[ADDR_W-1:AW+2] != '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (prog_start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_final)    w_state_nxt = S_RUN;
            S_RUN:   if (prog_start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length clears one edge after entering LOAD so a same-edge fetch sees the old program.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + AW'(1);
            end
            if (w_load) begin
                r_len <= w_final ? (AW+1)'(r_cnt) + (AW+1)'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_cnt] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_serve;
            r_err      <= w_serve && !(w_run && !w_bad);
            if (w_serve) begin
                r_rd <= (w_run && !w_bad) ? r_mem[w_idx] : NOP_WORD;
            end
        end
    end

    assign prog_ready = w_load;
    assign busy       = w_load;
    assign prog_done  = r_done;
    assign prog_len   = r_len;
    assign RD         = r_rd;
    assign rd_valid   = r_rd_valid;
    assign fetch_err  = r_err;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: fetch vector table, scoreboarded responses,
// and directed load / reset / reload sequences.
module tb_instr_mem_prog;

    localparam int          DEPTH = 1024;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_start;
    logic          prog_valid;
    logic [31:0]   prog_data;
    logic          prog_last;
    logic          prog_ready;
    logic          prog_done;
    logic [LW-1:0] prog_len;
    logic          busy;
    logic          fetch_req;
    logic [31:0]   A;
    logic [31:0]   RD;
    logic          rd_valid;
    logic          fetch_err;

    instr_mem_prog #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_start (prog_start),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_len   (prog_len),
        .busy       (busy),
        .fetch_req  (fetch_req),
        .A          (A),
        .RD         (RD),
        .rd_valid   (rd_valid),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (prog_done) done_cnt++;

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] dat(input int kind, input int i);
        logic [31:0] w;
        if (kind == 0) begin
            if (i == 0)       w = 32'h001020ab;
            else if (i == 1)  w = 32'h003010ab;
            else if (i == 14) w = 32'h00119133;
            else              w = 32'h00A00093 + (32'(i) << 8);
        end else if (kind == 1) begin
            w = 32'hA0000000 + 32'(i);
        end else begin
            w = 32'hB0000000 + 32'(i);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] addr, input bit ev,
                        input logic [31:0] erd, input bit eerr, input string name);
        exp_t e;
        fetch_req = 1'b1;
        A         = addr;
        if (ev) begin
            e.err = eerr;
            e.rd  = erd;
            sb.push_back(e);
        end
        tick();
        fetch_req = 1'b0;
        chk({name, ".valid"}, 32'(rd_valid), 32'(ev));
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.sb actual=response required=none", name);
            end else begin
                e = sb.pop_front();
                chk({name, ".err"}, 32'(fetch_err), 32'(e.err));
                chk({name, ".rd"}, RD, e.rd);
            end
        end else begin
            chk({name, ".err0"}, 32'(fetch_err), 32'(0));
            while (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic load(input int n, input bit start, input bit last,
                        input bit gaps, input int kind);
        int guard;
        if (start) begin
            prog_start = 1'b1;
            tick();
            prog_start = 1'b0;
            chk("load.busy", 32'(busy), 32'(1));
            chk("load.ready", 32'(prog_ready), 32'(1));
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 4 == 2)) begin
                prog_valid = 1'b0;
                tick();
            end
            prog_valid = 1'b1;
            prog_data  = dat(kind, i);
            prog_last  = last && (i == n - 1);
            guard = 0;
            while (!prog_ready && guard < 8) begin
                tick();
                guard++;
            end
            if (guard == 8) begin
                checks++;
                failures++;
                $display("FAIL load.stall actual=ready_low required=ready_high");
                break;
            end
            tick();
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".RD"}, RD, 32'(0));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(0));
        chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(0));
        chk({tag, ".prog_ready"}, 32'(prog_ready), 32'(0));
        chk({tag, ".prog_done"}, 32'(prog_done), 32'(0));
        chk({tag, ".busy"}, 32'(busy), 32'(0));
        chk({tag, ".prog_len"}, 32'(prog_len), 32'(0));
    endtask

    vec_t vt[10];

    initial begin
        rst        = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        fetch_req  = 1'b0;
        A          = '0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();

        step(32'h0, 1, NOP, 1, "idle_fetch");
        chk("idle.ready", 32'(prog_ready), 32'(0));
        chk("idle.len", 32'(prog_len), 32'(0));

        load(15, 1, 1, 1, 0);
        chk("l15.done", 32'(prog_done), 32'(1));
        chk("l15.busy", 32'(busy), 32'(0));
        chk("l15.ready", 32'(prog_ready), 32'(0));
        chk("l15.len", 32'(prog_len), 32'(15));
        tick();
        chk("l15.done_drop", 32'(prog_done), 32'(0));
        chk("l15.done_cnt", 32'(done_cnt), 32'(1));

        vt[0] = '{32'h38,       1'b0, dat(0, 14)};
        vt[1] = '{32'h3C,       1'b1, NOP};
        vt[2] = '{32'h00,       1'b0, dat(0, 0)};
        vt[3] = '{32'h02,       1'b1, NOP};
        vt[4] = '{32'h04,       1'b0, dat(0, 1)};
        vt[5] = '{32'h1000,     1'b1, NOP};
        vt[6] = '{32'h01,       1'b1, NOP};
        vt[7] = '{32'h80000000, 1'b1, NOP};
        vt[8] = '{32'hFFC,      1'b1, NOP};
        vt[9] = '{32'h20,       1'b0, dat(0, 8)};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].a, 1, vt[i].rd, vt[i].err, $sformatf("vec%0d", i));
        end
        tick();
        chk("hold.valid", 32'(rd_valid), 32'(0));
        chk("hold.err", 32'(fetch_err), 32'(0));
        chk("hold.rd", RD, vt[9].rd);

        load(DEPTH, 1, 0, 0, 1);
        chk("full.len", 32'(prog_len), 32'(DEPTH));
        chk("full.ready", 32'(prog_ready), 32'(0));
        chk("full.done", 32'(prog_done), 32'(1));
        prog_valid = 1'b1;
        prog_data  = 32'hDEADBEEF;
        chk("full.extra_ready", 32'(prog_ready), 32'(0));
        tick();
        prog_valid = 1'b0;
        chk("full.busy", 32'(busy), 32'(0));
        chk("full.len_hold", 32'(prog_len), 32'(DEPTH));
        step(32'h0, 1, dat(1, 0), 0, "full_first");
        step(32'((DEPTH - 1) * 4), 1, dat(1, DEPTH - 1), 0, "full_last");
        step(32'(DEPTH * 4), 1, NOP, 1, "full_oob");

        load(5, 1, 0, 0, 2);
        chk("mid.busy", 32'(busy), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk_reset("midreset");
        tick();
        rst = 1'b1;
        tick();
        step(32'h0, 1, NOP, 1, "post_reset");
        chk("post_reset.len", 32'(prog_len), 32'(0));

        load(3, 1, 1, 0, 0);
        chk("old.len", 32'(prog_len), 32'(3));
        tick();
        prog_start = 1'b1;
        step(32'h4, 1, dat(0, 1), 0, "reload_old");
        prog_start = 1'b0;
        chk("reload.busy", 32'(busy), 32'(1));
        chk("reload.len_old", 32'(prog_len), 32'(3));
        tick();
        chk("reload.len_clr", 32'(prog_len), 32'(0));
        step(32'h4, 0, 32'h0, 0, "load_fetch");
        chk("load_fetch.rd_hold", RD, dat(0, 1));
        load(2, 0, 1, 0, 2);
        chk("new.len", 32'(prog_len), 32'(2));
        chk("new.done", 32'(prog_done), 32'(1));
        step(32'h4, 1, dat(2, 1), 0, "new_word1");
        step(32'h8, 1, NOP, 1, "new_oob");
        step(32'h0, 1, dat(2, 0), 0, "new_word0");
        tick();
        chk("done_total", 32'(done_cnt), 32'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_prog.md
Name: instr_mem_prog

Overview:
Parametrised successor to the core's hard-initialised instruction memory. It adds a runtime program-load port, so host/testbench streams instruction words in with a valid/ready handshake, and a registered one-cycle fetch port with valid and error flags. It sits between the program loader (host or DMA) and the RISC-V/CNN core fetch stage. Only the loaded region is fetchable; everything else returns a NOP.

Parameters:
DEPTH, 1024, number of instruction words; must be a power of two, at least 4
ADDR_W, 32, fetch byte-address width
DATA_W, 32, instruction word width
NOP_WORD, 32'h00000013, word returned on an error or an unloaded fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
prog_start  in  1  pulse: begin a new program load (discards the previous program)
prog_valid  in  1  prog_data is valid this cycle
prog_data  in  DATA_W  instruction word to write
prog_last  in  1  qualifies prog_data as the final word of the program
prog_ready  out  1  block accepts a prog word this cycle
prog_done  out  1  one-cycle pulse when a load completes
prog_len  out  clog2(DEPTH)+1  number of words in the loaded program
busy  out  1  high while in LOAD
fetch_req  in  1  fetch request, sampled with A
A  in  ADDR_W  fetch byte address; word index is A[clog2(DEPTH)+1:2]
RD  out  DATA_W  fetched instruction, registered
rd_valid  out  1  RD is updated this cycle (response to the previous cycle's fetch_req)
fetch_err  out  1  qualifies rd_valid: the fetch was misaligned, out of loaded range, or outside DEPTH

Behaviour:
- Reset (rst=0, async): state=IDLE, RD=0, rd_valid=0, fetch_err=0, prog_ready=0, prog_done=0, busy=0, prog_len=0, word counter=0. Memory array is not cleared; contents are unreachable because prog_len=0.
- States: IDLE, LOAD, RUN.
- IDLE -> LOAD on prog_start.
- RUN -> LOAD on prog_start.
- LOAD -> RUN on an accepted word that has prog_last=1, or on acceptance of word index DEPTH-1 (forced end).
- On entering LOAD:
  - counter=0, prog_len=0.
  - prog_ready and busy go high the cycle after prog_start.
- In LOAD:
  - Handshake: a word is accepted when prog_valid and prog_ready are high on the same edge.
  - Accepted word: mem[counter] <= prog_data, counter++.
  - prog_start while already in LOAD is ignored.
- On completion:
  - prog_len = counter+1 (count including the final word).
  - prog_done pulses high for exactly one cycle.
  - prog_ready and busy drop in the same cycle.
- Fetch (RUN only), one-cycle latency:
  - On an edge with fetch_req=1: rd_valid=1 next cycle.
  - If A[1:0]!=0, or word index >= prog_len, or A bits above the index are nonzero: RD=NOP_WORD, fetch_err=1.
  - Otherwise: RD=mem[index], fetch_err=0.
  - Back-to-back fetches every cycle are supported.
- fetch_req=0: rd_valid=0, fetch_err=0, RD holds its last value.
- fetch_req in IDLE: rd_valid=1, RD=NOP_WORD, fetch_err=1.
- fetch_req in LOAD: rd_valid=0 and RD holds, so the core must stall on busy.
- prog_start and fetch_req on the same edge in RUN:
  - The fetch is serviced normally against the old program.
  - LOAD is entered on that edge.
  - prog_len clears on the next edge.
- Reset asserted mid-LOAD: returns to IDLE, prog_len=0, and the partial program is unfetchable.
- Memory write and fetch never occur in the same cycle, so no read-during-write rule is needed.

Test Plan:
- Reset, then fetch_req with A=0 -> next cycle rd_valid=1, fetch_err=1, RD=32'h00000013; prog_ready=0, prog_len=0.
- prog_start, then stream 15 words (0x001020ab, 0x003010ab, ..., last 0x00119133 with prog_last), inserting prog_valid gaps -> prog_done pulses once, prog_len=15, busy low afterwards; fetch A=0x38 -> RD=0x00119133, fetch_err=0.
- After that load, fetch A=0x3C (index 15) -> RD=NOP_WORD, fetch_err=1; fetch A=0x02 -> fetch_err=1; fetch A=0x1000 -> fetch_err=1.
- Stream DEPTH words without prog_last -> automatic end after word DEPTH-1, prog_len=DEPTH; an extra prog_valid is not accepted (prog_ready=0).
- Pull rst low after 5 accepted words -> all outputs return to reset values immediately; fetch A=0 -> fetch_err=1.
- Reload: in RUN, fetch A=4 with prog_start on the same edge -> old word returned; load 2 new words -> prog_len=2; fetch A=4 returns the new word; fetch_req during LOAD -> rd_valid=0.
